// File: rtl/usb_stream_arbiter.sv
// rtl/usb_stream_arbiter.sv - round-robin packetiser sharing one byte stream among NUM_SRC FWFT sources
module usb_stream_arbiter #(
    parameter int         NUM_SRC   = 4,
    parameter int         AVAIL_W   = 13,
    parameter int         MAX_BURST = 64,
    parameter logic [3:0] HDR_MAGIC = 4'hA
) (
    input  logic                       mclk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_SRC*AVAIL_W-1:0] src_avail,
    input  logic [NUM_SRC*8-1:0]       src_data,
    output logic [NUM_SRC-1:0]         src_rd,
    input  logic                       have_space,
    output logic [7:0]                 out_data,
    output logic                       out_wr,
    output logic                       busy
);

    localparam int CW = (AVAIL_W > 9) ? AVAIL_W : 9;
    localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_LEN, S_DATA} state_t;

    state_t      state_q, state_d;
    logic [3:0]  g_q, g_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  len_m1_q, len_m1_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_wr_q, out_wr_d;

    logic          req_any;
    logic [3:0]    grant;
    logic [CW-1:0] grant_avail;
    logic [CW-1:0] burst;
    logic [7:0]    head_byte;

    // Walk offsets from far to near so the nearest requester after last wins.
    always_comb begin
        int idx;
        req_any = 1'b0;
        grant   = last_q;
        idx     = 0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            idx = (int'(last_q) + off) % NUM_SRC;
            if (src_avail[idx*AVAIL_W +: AVAIL_W] != '0) begin
                req_any = 1'b1;
                grant   = 4'(idx);
            end
        end
    end

    always_comb begin
        grant_avail = '0;
        head_byte   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == 4'(i)) grant_avail = CW'(src_avail[i*AVAIL_W +: AVAIL_W]);
            if (g_q == 4'(i))   head_byte   = src_data[i*8 +: 8];
        end
        burst = (grant_avail > MAX_B) ? MAX_B : grant_avail;
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        last_d     = last_q;
        len_m1_d   = len_m1_q;
        cnt_d      = cnt_q;
        out_wr_d   = 1'b0;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (enable && req_any) begin
                    g_d      = grant;
                    last_d   = grant;
                    len_m1_d = 8'(burst - CW'(1));
                    cnt_d    = 8'(burst - CW'(1));
                    state_d  = S_HDR;
                end
            end
            S_HDR: begin
                if (have_space) begin
                    out_wr_d   = 1'b1;
                    out_data_d = {HDR_MAGIC, g_q};
                    state_d    = S_LEN;
                end
            end
            S_LEN: begin
                if (have_space) begin
                    out_wr_d   = 1'b1;
                    out_data_d = len_m1_q;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                // cnt_q holds bytes remaining minus one
                if (have_space) begin
                    out_wr_d   = 1'b1;
                    out_data_d = head_byte;
                    if (cnt_q == 8'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated by reset so a reset edge never consumes a byte that gets abandoned.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rd[i] = reset && (state_q == S_DATA) && have_space && (g_q == 4'(i));
        end
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            g_q        <= 4'd0;
            last_q     <= 4'(NUM_SRC - 1);
            len_m1_q   <= 8'd0;
            cnt_q      <= 8'd0;
            out_data_q <= 8'd0;
            out_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            last_q     <= last_d;
            len_m1_q   <= len_m1_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_wr_q   <= out_wr_d;
        end
    end

    assign out_data = out_data_q;
    assign out_wr   = out_wr_q;
    assign busy     = (state_q != S_IDLE);

endmodule
